// File: rtl/oscope_capture_mc_if.sv
// Capture/readout bus for oscope_capture_mc: digitizer input, capture
// configuration, host read port and status.
interface oscope_capture_mc_if #(
  parameter int NCH     = 8,
  parameter int DW      = 16,
  parameter int BUF_AW  = 13,
  parameter int DECIM_W = 12,
  parameter int CW      = 3
);
  logic [NCH*DW-1:0]    adc_data;
  logic                 adc_valid;
  logic                 arm;
  logic [1:0]           trig_mode;
  logic [CW-1:0]        trig_ch;
  logic [DW-1:0]        trig_level;
  logic                 trig_ext;
  logic [BUF_AW-1:0]    pretrig;
  logic [DECIM_W-1:0]   decim;
  logic [CW+BUF_AW-1:0] rd_addr;
  logic [DW-1:0]        rd_data;
  logic                 busy;
  logic                 done;
  logic [BUF_AW-1:0]    trig_addr;

  modport master (
    output adc_data, adc_valid, arm, trig_mode, trig_ch, trig_level, trig_ext,
           pretrig, decim, rd_addr,
    input  rd_data, busy, done, trig_addr
  );

  modport slave (
    input  adc_data, adc_valid, arm, trig_mode, trig_ch, trig_level, trig_ext,
           pretrig, decim, rd_addr,
    output rd_data, busy, done, trig_addr
  );
endinterface

// File: rtl/oscope_capture_mc.sv
// Multi-channel oscilloscope capture: decimated circular recording of NCH
// channels with pre-trigger history, selectable trigger, 2-cycle host readout.
module oscope_capture_mc #(
  parameter int NCH     = 8,
  parameter int DW      = 16,
  parameter int BUF_AW  = 13,
  parameter int DECIM_W = 12,
  parameter int CW      = 3
) (
  input  logic               clk,
  input  logic               reset,
  oscope_capture_mc_if.slave bus
);
  localparam int DEPTH = 1 << BUF_AW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [DECIM_W-1:0]   dcnt_q, dcnt_d;
  logic [BUF_AW-1:0]    wptr_q, wptr_d;
  logic [BUF_AW:0]      fill_q, fill_d;
  logic [BUF_AW-1:0]    trig_addr_q, trig_addr_d;
  logic signed [DW-1:0] prev_q, prev_d;
  logic                 prev_vld_q, prev_vld_d;

  // Configuration snapshot taken at arm
  logic [1:0]           mode_q, mode_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic signed [DW-1:0] level_q, level_d;
  logic [BUF_AW-1:0]    pe_q, pe_d;
  logic [DECIM_W-1:0]   decim_q, decim_d;

  logic                 busy;
  logic                 store;
  logic                 hit;
  logic signed [DW-1:0] cur_s;
  logic [BUF_AW:0]      post_target;

  logic [NCH*DW-1:0]    buf_mem [DEPTH];
  logic [NCH*DW-1:0]    rd_word_q;
  logic [CW-1:0]        rd_ch_q;
  logic [DW-1:0]        rd_data_q;
  logic [DW-1:0]        rd_sel;
  logic [BUF_AW-1:0]    rd_phys;

  assign busy        = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign store       = busy && bus.adc_valid && !bus.arm && !reset && (dcnt_q == decim_q);
  // pretrig cannot exceed DEPTH-1 at this width, so it is already the effective depth
  assign post_target = {1'b1, {BUF_AW{1'b0}}} - {1'b0, pe_q};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_s = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CW'(k)) cur_s = bus.adc_data[k*DW +: DW];
    end
  end

  always_comb begin
    hit = 1'b0;
    case (mode_q)
      2'd0:    hit = prev_vld_q && (prev_q < level_q) && (cur_s >= level_q);
      2'd1:    hit = prev_vld_q && (prev_q > level_q) && (cur_s <= level_q);
      2'd2:    hit = bus.trig_ext;
      default: hit = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    trig_addr_d = trig_addr_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    mode_d      = mode_q;
    ch_d        = ch_q;
    level_d     = level_q;
    pe_d        = pe_q;
    decim_d     = decim_q;

    if (bus.arm) begin
      state_d    = (bus.pretrig == '0) ? S_ARMED : S_PRE;
      dcnt_d     = '0;
      fill_d     = '0;
      prev_vld_d = 1'b0;
      mode_d     = bus.trig_mode;
      ch_d       = bus.trig_ch;
      level_d    = bus.trig_level;
      pe_d       = bus.pretrig;
      decim_d    = bus.decim;
    end else begin
      if (busy && bus.adc_valid) dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;
      if (store) begin
        wptr_d     = wptr_q + 1'b1;
        prev_d     = cur_s;
        prev_vld_d = 1'b1;
        case (state_q)
          S_PRE: begin
            fill_d = fill_q + 1'b1;
            if (fill_q + 1'b1 == {1'b0, pe_q}) begin
              state_d = S_ARMED;
              fill_d  = '0;
            end
          end
          S_ARMED: begin
            if (hit) begin
              trig_addr_d = wptr_q;
              fill_d      = {{BUF_AW{1'b0}}, 1'b1};
              // With maximal pre-trigger the trigger sample is the only post sample
              state_d     = (post_target == {{BUF_AW{1'b0}}, 1'b1}) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            fill_d = fill_q + 1'b1;
            if (fill_q + 1'b1 == post_target) state_d = S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      wptr_q      <= '0;
      fill_q      <= '0;
      trig_addr_q <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      mode_q      <= '0;
      ch_q        <= '0;
      level_q     <= '0;
      pe_q        <= '0;
      decim_q     <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      trig_addr_q <= trig_addr_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      mode_q      <= mode_d;
      ch_q        <= ch_d;
      level_q     <= level_d;
      pe_q        <= pe_d;
      decim_q     <= decim_d;
    end
  end

  // NOTE: the sample RAM and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (store) buf_mem[wptr_q] <= bus.adc_data;
  end

  assign rd_phys = trig_addr_q - pe_q + bus.rd_addr[BUF_AW-1:0];

  always_ff @(posedge clk) begin
    rd_word_q <= buf_mem[rd_phys];
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_ch_q == CW'(k)) rd_sel = rd_word_q[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ch_q   <= '0;
      rd_data_q <= '0;
    end else begin
      rd_ch_q   <= bus.rd_addr[CW+BUF_AW-1 -: CW];
      rd_data_q <= rd_sel;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == S_DONE);
  assign bus.trig_addr = trig_addr_q;
endmodule

// File: tb/tb_oscope_capture_mc.sv
// Directed bench for oscope_capture_mc: ramp/sine sources, every trigger mode,
// decimation, maximal pre-trigger, restart/reset and pipelined readout.
module tb_oscope_capture_mc;
  localparam int NCH     = 8;
  localparam int DW      = 16;
  localparam int BUF_AW  = 13;
  localparam int DECIM_W = 12;
  localparam int CW      = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oscope_capture_mc_if #(.NCH(NCH), .DW(DW), .BUF_AW(BUF_AW), .DECIM_W(DECIM_W), .CW(CW)) bus ();

  oscope_capture_mc #(.NCH(NCH), .DW(DW), .BUF_AW(BUF_AW), .DECIM_W(DECIM_W), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // n = index of the next valid sample offered since the last arm
  int n;
  bit sine_src, toggle_valid, vphase, valid_en;
  int ext_at;
  int sine_tab [16] = '{0, 383, 707, 924, 1000, 924, 707, 383,
                        0, -383, -707, -924, -1000, -924, -707, -383};

  function automatic logic [NCH*DW-1:0] gen(input int idx);
    logic [NCH*DW-1:0] w;
    for (int k = 0; k < NCH; k++) begin
      if (sine_src && k == 3) w[k*DW +: DW] = DW'(sine_tab[idx % 16]);
      else                    w[k*DW +: DW] = DW'(idx + 1000 * k);
    end
    return w;
  endfunction

  task automatic drive_adc();
    bus.adc_valid = valid_en && (toggle_valid ? vphase : 1'b1);
    bus.adc_data  = gen(n);
    bus.trig_ext  = (n == ext_at);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.adc_valid) n++;
    vphase = ~vphase;
    drive_adc();
  endtask

  task automatic do_arm(input logic [1:0] mode, input int ch, input int level, input int pre,
                        input int dec, input bit sine, input bit tog);
    bus.trig_mode  = mode;
    bus.trig_ch    = CW'(ch);
    bus.trig_level = DW'(level);
    bus.pretrig    = BUF_AW'(pre);
    bus.decim      = DECIM_W'(dec);
    bus.arm        = 1'b1;
    bus.adc_valid  = 1'b0;
    bus.trig_ext   = 1'b0;
    @(posedge clk);
    #1;
    bus.arm      = 1'b0;
    n            = 0;
    sine_src     = sine;
    toggle_valid = tog;
    vphase       = 1'b1;
    valid_en     = 1'b1;
    ext_at       = -1;
    drive_adc();
  endtask

  task automatic stall();
    valid_en      = 1'b0;
    bus.adc_valid = 1'b0;
    bus.trig_ext  = 1'b0;
  endtask

  task automatic rd(input int ch, input int idx, output logic [DW-1:0] d);
    bus.rd_addr = {CW'(ch), BUF_AW'(idx)};
    tick();
    tick();
    d = bus.rd_data;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    int c;
    c = 0;
    while (!bus.done && c < budget) begin
      tick();
      c++;
    end
    ok = bus.done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.arm = 1'b0; bus.rd_addr = '0; bus.trig_mode = '0; bus.trig_ch = '0;
    bus.trig_level = '0; bus.pretrig = '0; bus.decim = '0;
    n = 0; sine_src = 0; toggle_valid = 0; vphase = 0; valid_en = 0; ext_at = -1;
    drive_adc();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.trig_addr !== '0) begin n_fail++; $display("FAIL reset_trig_addr: got %0d want 0", bus.trig_addr); end
    n_checks++; if (bus.rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %0d want 0", bus.rd_data); end
  endtask

  task automatic test_ramp_immediate();
    bit ok;
    logic [DW-1:0] d;
    do_arm(2'd3, 2, 0, 100, 0, 0, 0);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ramp_busy: got %b want 1", bus.busy); end
    // Mid-capture config changes must be ignored
    bus.pretrig = BUF_AW'(5); bus.trig_mode = 2'd0; bus.decim = DECIM_W'(7);
    run_until_done(9000, ok);
    stall();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ramp_done: done not seen within budget"); end
    n_checks++; if (n != 8192) begin n_fail++; $display("FAIL ramp_store_count: got %0d want 8192", n); end
    n_checks++; if (bus.trig_addr !== BUF_AW'(100)) begin n_fail++; $display("FAIL ramp_trig_addr: got %0d want 100", bus.trig_addr); end
    rd(2, 0, d);
    n_checks++; if (d !== DW'(2000)) begin n_fail++; $display("FAIL ramp_rd_ch2_0: got %0d want 2000", d); end
    rd(2, 100, d);
    n_checks++; if (d !== DW'(2100)) begin n_fail++; $display("FAIL ramp_rd_ch2_100: got %0d want 2100", d); end
    rd(7, 8191, d);
    n_checks++; if (d !== DW'(15191)) begin n_fail++; $display("FAIL ramp_rd_ch7_newest: got %0d want 15191", d); end
  endtask

  task automatic test_mode0_rising();
    bit ok;
    logic [DW-1:0] d;
    do_arm(2'd0, 3, 0, 0, 0, 1, 0);
    run_until_done(9000, ok);
    stall();
    n_checks++; if (!ok || n != 8208) begin n_fail++; $display("FAIL rise_done: done=%b n=%0d want 1/8208", ok, n); end
    n_checks++; if (bus.trig_addr !== BUF_AW'(16)) begin n_fail++; $display("FAIL rise_trig_addr: got %0d want 16", bus.trig_addr); end
    rd(3, 0, d);
    n_checks++; if (d !== DW'(0)) begin n_fail++; $display("FAIL rise_rd_trig: got %0d want 0", $signed(d)); end
    rd(3, 8191, d);
    n_checks++; if (d !== DW'(-383)) begin n_fail++; $display("FAIL rise_rd_preceding: got %0d want -383", $signed(d)); end
    rd(0, 0, d);
    n_checks++; if (d !== DW'(16)) begin n_fail++; $display("FAIL rise_rd_ch0: got %0d want 16", d); end
  endtask

  task automatic test_mode1_falling();
    int c;
    do_arm(2'd1, 3, 0, 0, 0, 1, 0);
    c = 0;
    while (n < 12 && c < 100) begin tick(); c++; end
    stall();
    n_checks++; if (bus.trig_addr !== BUF_AW'(24)) begin n_fail++; $display("FAIL fall_trig_addr: got %0d want 24", bus.trig_addr); end
    n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL fall_busy: busy=%b done=%b want 1/0", bus.busy, bus.done); end
  endtask

  task automatic test_decimation();
    int c;
    logic [DW-1:0] d;
    int exp_v [4] = '{3, 7, 11, 15};
    do_arm(2'd3, 0, 0, 0, 3, 0, 1);
    c = 0;
    while (n < 16 && c < 200) begin tick(); c++; end
    stall();
    n_checks++; if (bus.trig_addr !== BUF_AW'(28)) begin n_fail++; $display("FAIL decim_trig_addr: got %0d want 28", bus.trig_addr); end
    for (int i = 0; i < 4; i++) begin
      rd(0, i, d);
      n_checks++; if (d !== DW'(exp_v[i])) begin n_fail++; $display("FAIL decim_rd_%0d: got %0d want %0d", i, d, exp_v[i]); end
    end
    rd(1, 1, d);
    n_checks++; if (d !== DW'(1007)) begin n_fail++; $display("FAIL decim_rd_ch1: got %0d want 1007", d); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL decim_stall_busy: got %b want 1", bus.busy); end
  endtask

  task automatic test_pretrig_max();
    bit ok;
    int c;
    logic [DW-1:0] d;
    do_arm(2'd2, 0, 0, 8191, 0, 0, 0);
    ext_at = 8200;
    c = 0;
    while (n < 8200 && c < 9000) begin tick(); c++; end
    n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL pmax_pre_ext: busy=%b done=%b want 1/0", bus.busy, bus.done); end
    run_until_done(10, ok);
    stall();
    n_checks++; if (!ok || n != 8201) begin n_fail++; $display("FAIL pmax_done: done=%b n=%0d want 1/8201", ok, n); end
    n_checks++; if (bus.trig_addr !== BUF_AW'(40)) begin n_fail++; $display("FAIL pmax_trig_addr: got %0d want 40", bus.trig_addr); end
    rd(0, 8191, d);
    n_checks++; if (d !== DW'(8200)) begin n_fail++; $display("FAIL pmax_rd_trig: got %0d want 8200", d); end
    rd(0, 0, d);
    n_checks++; if (d !== DW'(9)) begin n_fail++; $display("FAIL pmax_rd_oldest: got %0d want 9", d); end
    rd(4, 8190, d);
    n_checks++; if (d !== DW'(12199)) begin n_fail++; $display("FAIL pmax_rd_ch4: got %0d want 12199", d); end
  endtask

  task automatic test_restart();
    bit ok;
    logic [DW-1:0] d;
    do_arm(2'd3, 0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_arm1: busy=%b done=%b want 1/0", bus.busy, bus.done); end
    repeat (20) tick();
    do_arm(2'd3, 0, 0, 50, 0, 0, 0);
    n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_rearm_post: busy=%b done=%b want 1/0", bus.busy, bus.done); end
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_in_pre: busy=%b done=%b want 0/0", bus.busy, bus.done); end
    n_checks++; if (bus.trig_addr !== '0 || bus.rd_data !== '0) begin n_fail++; $display("FAIL rst_clear: trig_addr=%0d rd_data=%0d want 0/0", bus.trig_addr, bus.rd_data); end
    repeat (5) tick();
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy=%b done=%b want 0/0", bus.busy, bus.done); end
    do_arm(2'd3, 0, 0, 0, 0, 0, 0);
    run_until_done(9000, ok);
    stall();
    n_checks++; if (!ok || n != 8192) begin n_fail++; $display("FAIL rst_full_capture: done=%b n=%0d want 1/8192", ok, n); end
    n_checks++; if (bus.trig_addr !== '0) begin n_fail++; $display("FAIL rst_trig_addr: got %0d want 0", bus.trig_addr); end
    rd(5, 0, d);
    n_checks++; if (d !== DW'(5000)) begin n_fail++; $display("FAIL rst_rd_ch5_0: got %0d want 5000", d); end
  endtask

  task automatic test_back_to_back();
    int ch_v  [6] = '{0, 1, 2, 9, 7, 3};
    int idx_v [6] = '{0, 1, 2, 5, 8191, 100};
    int exp_v [6] = '{0, 1001, 2002, 0, 15191, 3100};
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) begin
        n_checks++;
        if (bus.rd_data !== DW'(exp_v[i-2])) begin
          n_fail++;
          $display("FAIL b2b_rd_%0d: got %0d want %0d", i - 2, bus.rd_data, exp_v[i-2]);
        end
      end
      if (i < 6) bus.rd_addr = {CW'(ch_v[i]), BUF_AW'(idx_v[i])};
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_immediate();
    test_mode0_rising();
    test_mode1_falling();
    test_decimation();
    test_pretrig_max();
    test_restart();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
